alu_sequencer: RTL and testbench

Hardwired control unit for the single-bus CPU datapath. It runs instruction fetch through the MDR, holds the instruction register, and steps each ALU instruction through the Y/Z register sequence. Each step drives one-hot bus-select, register-load and ALU-operation strobes. It sits beside the datapath: its outputs connect to the datapath's control inputs, and it observes the datapath's PC and bus.

---
 rtl/alu_sequencer.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - hardwired fetch/execute control unit for the single-bus CPU datapath
// Strobes are registered from (next state, next IR), so each output is a pure function of (state, ir).
module alu_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic        mem_ready,
  input  logic [31:0] pc,
  input  logic [31:0] bus_in,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  output logic        read_mdr,
  output logic        mdr_in,
  output logic [15:0] reg_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        zhi_in,
  output logic        zlo_in,
  output logic        pc_in,
  output logic        y_in,
  output logic [31:0] bus_sel,
  output logic [12:0] alu_op,
  output logic [31:0] ir,
  output logic        run,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_F0, S_F1, S_F2, S_F3, S_F4, S_F5, S_E0, S_E1, S_E2, S_E3, S_HALT
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [4:0] SEL_HI  = 5'd16;
  localparam logic [4:0] SEL_LO  = 5'd17;
  localparam logic [4:0] SEL_ZHI = 5'd18;
  localparam logic [4:0] SEL_ZLO = 5'd19;
  localparam logic [4:0] SEL_PC  = 5'd20;
  localparam logic [4:0] SEL_MDR = 5'd21;

  localparam logic [12:0] ALU_NOT = 13'h0001;
  localparam logic [12:0] ALU_NEG = 13'h0080;

  function automatic logic [12:0] alu_strobe(input logic [4:0] op);
    logic [12:0] s;
    s = '0;
    case (op)
      OP_NOT:  s[0]  = 1'b1;
      OP_OR:   s[1]  = 1'b1;
      OP_AND:  s[2]  = 1'b1;
      OP_SHR:  s[3]  = 1'b1;
      OP_SHRA: s[4]  = 1'b1;
      OP_SHL:  s[5]  = 1'b1;
      OP_ADD:  s[6]  = 1'b1;
      OP_NEG:  s[7]  = 1'b1;
      OP_SUB:  s[8]  = 1'b1;
      OP_ROR:  s[9]  = 1'b1;
      OP_ROL:  s[10] = 1'b1;
      OP_DIV:  s[11] = 1'b1;
      OP_MUL:  s[12] = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] sel(input logic [4:0] idx);
    return 32'd1 << idx;
  endfunction

  function automatic logic is_binary(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        mem_rd_q, mem_rd_d;
  logic        read_mdr_q, read_mdr_d;
  logic        mdr_in_q, mdr_in_d;
  logic [15:0] reg_in_q, reg_in_d;
  logic        hi_in_q, hi_in_d;
  logic        lo_in_q, lo_in_d;
  logic        zhi_in_q, zhi_in_d;
  logic        zlo_in_q, zlo_in_d;
  logic        pc_in_q, pc_in_d;
  logic        y_in_q, y_in_d;
  logic [31:0] bus_sel_q, bus_sel_d;
  logic [12:0] alu_op_q, alu_op_d;
  logic        run_q, run_d;
  logic        illegal_q, illegal_d;

  logic [4:0] op_q;
  logic [4:0] op_n;
  logic [3:0] ra_n, rb_n, rc_n;

  assign op_q = ir_q[31:27];
  assign op_n = ir_d[31:27];
  assign ra_n = ir_d[26:23];
  assign rb_n = ir_d[22:19];
  assign rc_n = ir_d[18:15];

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_F0: if (mem_ready) state_d = S_F1;
      S_F1: state_d = S_F2;
      S_F2: begin
        state_d = S_F3;
        ir_d    = bus_in;
      end
      S_F3: state_d = S_F4;
      S_F4: state_d = S_F5;
      S_F5: state_d = (op_q == OP_HALT) ? S_HALT : S_E0;
      S_E0: state_d = (is_binary(op_q) || is_muldiv(op_q) || is_unary(op_q)) ? S_E1 : S_F0;
      S_E1: state_d = (is_binary(op_q) || is_muldiv(op_q)) ? S_E2 : S_F0;
      S_E2: state_d = is_muldiv(op_q) ? S_E3 : S_F0;
      S_E3: state_d = S_F0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_F0;
    endcase
  end

  // Strobes for the state about to be entered, decoded from the IR that will be held there.
  always_comb begin
    mem_rd_d   = 1'b0;
    read_mdr_d = 1'b0;
    mdr_in_d   = 1'b0;
    reg_in_d   = '0;
    hi_in_d    = 1'b0;
    lo_in_d    = 1'b0;
    zhi_in_d   = 1'b0;
    zlo_in_d   = 1'b0;
    pc_in_d    = 1'b0;
    y_in_d     = 1'b0;
    bus_sel_d  = '0;
    alu_op_d   = '0;
    illegal_d  = 1'b0;
    run_d      = (state_d != S_HALT);
    case (state_d)
      S_F0: mem_rd_d = 1'b1;
      S_F1: begin
        read_mdr_d = 1'b1;
        mdr_in_d   = 1'b1;
      end
      S_F2: bus_sel_d = sel(SEL_MDR);
      S_F3: begin
        bus_sel_d = sel(SEL_PC);
        alu_op_d  = ALU_NOT;
        zlo_in_d  = 1'b1;
      end
      S_F4: begin
        bus_sel_d = sel(SEL_ZLO);
        alu_op_d  = ALU_NEG;
        zlo_in_d  = 1'b1;
      end
      S_F5: begin
        bus_sel_d = sel(SEL_ZLO);
        pc_in_d   = 1'b1;
      end
      S_E0: begin
        if (is_binary(op_n) || is_muldiv(op_n)) begin
          bus_sel_d = sel({1'b0, rb_n});
          y_in_d    = 1'b1;
        end else if (is_unary(op_n)) begin
          bus_sel_d = sel({1'b0, rb_n});
          alu_op_d  = alu_strobe(op_n);
          zlo_in_d  = 1'b1;
        end else if (op_n == OP_MFHI) begin
          bus_sel_d = sel(SEL_HI);
          reg_in_d  = 16'd1 << ra_n;
        end else if (op_n == OP_MFLO) begin
          bus_sel_d = sel(SEL_LO);
          reg_in_d  = 16'd1 << ra_n;
        end else if (op_n != OP_NOP) begin
          illegal_d = 1'b1;
        end
      end
      S_E1: begin
        if (is_unary(op_n)) begin
          bus_sel_d = sel(SEL_ZLO);
          reg_in_d  = 16'd1 << ra_n;
        end else begin
          bus_sel_d = sel({1'b0, rc_n});
          alu_op_d  = alu_strobe(op_n);
          zhi_in_d  = 1'b1;
          zlo_in_d  = 1'b1;
        end
      end
      S_E2: begin
        bus_sel_d = sel(SEL_ZLO);
        if (is_muldiv(op_n)) lo_in_d = 1'b1;
        else                 reg_in_d = 16'd1 << ra_n;
      end
      S_E3: begin
        bus_sel_d = sel(SEL_ZHI);
        hi_in_d   = 1'b1;
      end
      default: run_d = (state_d != S_HALT);
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_F0;
      ir_q       <= '0;
      mem_rd_q   <= 1'b1;
      read_mdr_q <= 1'b0;
      mdr_in_q   <= 1'b0;
      reg_in_q   <= '0;
      hi_in_q    <= 1'b0;
      lo_in_q    <= 1'b0;
      zhi_in_q   <= 1'b0;
      zlo_in_q   <= 1'b0;
      pc_in_q    <= 1'b0;
      y_in_q     <= 1'b0;
      bus_sel_q  <= '0;
      alu_op_q   <= '0;
      run_q      <= 1'b1;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      mem_rd_q   <= mem_rd_d;
      read_mdr_q <= read_mdr_d;
      mdr_in_q   <= mdr_in_d;
      reg_in_q   <= reg_in_d;
      hi_in_q    <= hi_in_d;
      lo_in_q    <= lo_in_d;
      zhi_in_q   <= zhi_in_d;
      zlo_in_q   <= zlo_in_d;
      pc_in_q    <= pc_in_d;
      y_in_q     <= y_in_d;
      bus_sel_q  <= bus_sel_d;
      alu_op_q   <= alu_op_d;
      run_q      <= run_d;
      illegal_q  <= illegal_d;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_rd_q ? pc : 32'd0;
  assign read_mdr = read_mdr_q;
  assign mdr_in   = mdr_in_q;
  assign reg_in   = reg_in_q;
  assign hi_in    = hi_in_q;
  assign lo_in    = lo_in_q;
  assign zhi_in   = zhi_in_q;
  assign zlo_in   = zlo_in_q;
  assign pc_in    = pc_in_q;
  assign y_in     = y_in_q;
  assign bus_sel  = bus_sel_q;
  assign alu_op   = alu_op_q;
  assign ir       = ir_q;
  assign run      = run_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - cycle-table and directed-sequence bench for alu_sequencer
// A small datapath model closes the loop so register results can be checked too.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        clr, mem_ready, dp_init;
  logic [31:0] pc_m, bus;
  logic        mem_rd, read_mdr, mdr_in, hi_in, lo_in, zhi_in, zlo_in, pc_in, y_in, run, illegal;
  logic [31:0] mem_addr, bus_sel, ir;
  logic [15:0] reg_in;
  logic [12:0] alu_op;
  logic [10:0] misc_act;

  alu_sequencer dut (
    .clk(clk), .clr(clr), .mem_ready(mem_ready), .pc(pc_m), .bus_in(bus),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .read_mdr(read_mdr), .mdr_in(mdr_in),
    .reg_in(reg_in), .hi_in(hi_in), .lo_in(lo_in), .zhi_in(zhi_in), .zlo_in(zlo_in),
    .pc_in(pc_in), .y_in(y_in), .bus_sel(bus_sel), .alu_op(alu_op), .ir(ir),
    .run(run), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign misc_act = {run, illegal, mem_rd, read_mdr, mdr_in, y_in, zhi_in, zlo_in, hi_in, lo_in, pc_in};

  localparam logic [10:0] M_RUN = 11'h400, M_ILL = 11'h200, M_RD = 11'h100, M_RMDR = 11'h080;
  localparam logic [10:0] M_MDRIN = 11'h040, M_Y = 11'h020, M_ZHI = 11'h010, M_ZLO = 11'h008;
  localparam logic [10:0] M_HI = 11'h004, M_LO = 11'h002, M_PC = 11'h001;

  // Datapath model: register file, Y, Z, HI/LO, PC, MDR and the ALU ops exercised here.
  logic [31:0] mem [64];
  logic [31:0] r [16];
  logic [31:0] y, zhi, zlo, hi, lo, mdr;
  logic [63:0] alu_res;

  always_comb begin
    bus = '0;
    for (int i = 0; i < 16; i++) if (bus_sel[i]) bus = bus | r[i];
    if (bus_sel[16]) bus = bus | hi;
    if (bus_sel[17]) bus = bus | lo;
    if (bus_sel[18]) bus = bus | zhi;
    if (bus_sel[19]) bus = bus | zlo;
    if (bus_sel[20]) bus = bus | pc_m;
    if (bus_sel[21]) bus = bus | mdr;
  end

  always_comb begin
    alu_res = '0;
    if (alu_op[0])       alu_res = {32'd0, ~bus};
    else if (alu_op[6])  alu_res = {32'd0, y + bus};
    else if (alu_op[7])  alu_res = {32'd0, -bus};
    else if (alu_op[12]) alu_res = {32'd0, y} * {32'd0, bus};
  end

  always @(posedge clk) begin
    if (dp_init) begin
      for (int i = 0; i < 16; i++) r[i] <= 32'd0;
      r[1] <= 32'd5;
      r[2] <= 32'd7;
      r[4] <= 32'h0001_0000;
      r[5] <= 32'h0001_0000;
      pc_m <= 32'd0;
      y <= 32'd0; zhi <= 32'd0; zlo <= 32'd0; mdr <= 32'd0;
      hi <= 32'hBEEF; lo <= 32'hDEAD;
    end else begin
      if (mdr_in) mdr <= read_mdr ? mem[pc_m[5:0]] : bus;
      for (int i = 0; i < 16; i++) if (reg_in[i]) r[i] <= bus;
      if (y_in)   y   <= bus;
      if (zhi_in) zhi <= alu_res[63:32];
      if (zlo_in) zlo <= alu_res[31:0];
      if (hi_in)  hi  <= bus;
      if (lo_in)  lo  <= bus;
      if (pc_in)  pc_m <= bus;
    end
  end

  typedef struct {
    logic        mr;
    logic [31:0] bs;
    logic [12:0] al;
    logic [15:0] ri;
    logic [10:0] misc;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bsel(input int n);
    return 32'd1 << n;
  endfunction

  function automatic logic [12:0] aop(input int n);
    return 13'd1 << n;
  endfunction

  function automatic logic [15:0] rin(input int n);
    return 16'd1 << n;
  endfunction

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                                      input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  task automatic push(input logic mr, input logic [31:0] bs, input logic [12:0] al,
                      input logic [15:0] ri, input logic [10:0] misc);
    vec_t v;
    v.mr = mr; v.bs = bs; v.al = al; v.ri = ri; v.misc = misc;
    vecs.push_back(v);
  endtask

  task automatic fetch(input int waits);
    for (int k = 0; k < waits; k++) push(1'b0, 32'd0, 13'd0, 16'd0, M_RUN | M_RD);
    push(1'b1, 32'd0, 13'd0, 16'd0, M_RUN | M_RD);
    push(1'b0, 32'd0, 13'd0, 16'd0, M_RUN | M_RMDR | M_MDRIN);
    push(1'b0, bsel(21), 13'd0, 16'd0, M_RUN);
    push(1'b0, bsel(20), aop(0), 16'd0, M_RUN | M_ZLO);
    push(1'b0, bsel(19), aop(7), 16'd0, M_RUN | M_ZLO);
    push(1'b0, bsel(19), 13'd0, 16'd0, M_RUN | M_PC);
  endtask

  initial begin
    int n;
    clr = 1'b1;
    mem_ready = 1'b1;
    dp_init = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = enc(5'b11001, 4'd0, 4'd0, 4'd0);
    mem[1]  = enc(5'b00011, 4'd3, 4'd1, 4'd2);
    mem[2]  = enc(5'b01111, 4'd0, 4'd4, 4'd5);
    mem[3]  = enc(5'b10010, 4'd6, 4'd1, 4'd0);
    mem[4]  = enc(5'b00011, 4'd3, 4'd3, 4'd3);
    mem[5]  = enc(5'b11000, 4'd8, 4'd0, 4'd0);
    mem[6]  = enc(5'b10111, 4'd9, 4'd0, 4'd0);
    mem[8]  = enc(5'b11111, 4'd1, 4'd2, 4'd3);
    mem[9]  = enc(5'b11010, 4'd0, 4'd0, 4'd0);
    mem[10] = enc(5'b01111, 4'd0, 4'd1, 4'd2);

    fetch(0); push(1'b0, 32'd0, 13'd0, 16'd0, M_RUN);
    fetch(0);
    push(1'b0, bsel(1), 13'd0, 16'd0, M_RUN | M_Y);
    push(1'b0, bsel(2), aop(6), 16'd0, M_RUN | M_ZHI | M_ZLO);
    push(1'b0, bsel(19), 13'd0, rin(3), M_RUN);
    fetch(0);
    push(1'b0, bsel(4), 13'd0, 16'd0, M_RUN | M_Y);
    push(1'b0, bsel(5), aop(12), 16'd0, M_RUN | M_ZHI | M_ZLO);
    push(1'b0, bsel(19), 13'd0, 16'd0, M_RUN | M_LO);
    push(1'b0, bsel(18), 13'd0, 16'd0, M_RUN | M_HI);
    fetch(0);
    push(1'b0, bsel(1), aop(0), 16'd0, M_RUN | M_ZLO);
    push(1'b0, bsel(19), 13'd0, rin(6), M_RUN);
    fetch(0);
    push(1'b0, bsel(3), 13'd0, 16'd0, M_RUN | M_Y);
    push(1'b0, bsel(3), aop(6), 16'd0, M_RUN | M_ZHI | M_ZLO);
    push(1'b0, bsel(19), 13'd0, rin(3), M_RUN);
    fetch(0); push(1'b0, bsel(17), 13'd0, rin(8), M_RUN);
    fetch(0); push(1'b0, bsel(16), 13'd0, rin(9), M_RUN);
    fetch(4); push(1'b0, 32'd0, 13'd0, 16'd0, M_RUN);
    fetch(0); push(1'b0, 32'd0, 13'd0, 16'd0, M_RUN | M_ILL);

    @(negedge clk);
    @(negedge clk);
    dp_init = 1'b0;
    clr = 1'b0;
    chk("reset.ir", ir, 96'd0);
    chk("reset.strobes", {bus_sel, alu_op, reg_in, misc_act}, {32'd0, 13'd0, 16'd0, M_RUN | M_RD});
    chk("reset.mem_addr", mem_addr, 96'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      mem_ready = vecs[i].mr;
      chk($sformatf("vec%0d.strobes", i), {bus_sel, alu_op, reg_in, misc_act},
          {vecs[i].bs, vecs[i].al, vecs[i].ri, vecs[i].misc});
      if ((vecs[i].misc & M_RD) != 11'd0) chk($sformatf("vec%0d.mem_addr", i), mem_addr, pc_m);
      if (i == 5) chk("nop.pc_before_f5", pc_m, 96'd0);
      if (i == 6) chk("nop.pc_after_f5", pc_m, 96'd1);
      @(negedge clk);
    end

    chk("add_twice.r3", r[3], 96'd24);
    chk("not.r6", r[6], 96'hFFFF_FFFA);
    chk("mflo.r8", r[8], 96'd0);
    chk("mfhi.r9", r[9], 96'd1);
    chk("mul.hi", hi, 96'd1);
    chk("mul.lo", lo, 96'd0);
    chk("illegal.r1_kept", r[1], 96'd5);
    chk("prog.pc", pc_m, 96'd9);
    chk("illegal.ir", ir, mem[8]);
    chk("illegal.next_f0", {mem_rd, run}, 96'd3);

    mem_ready = 1'b1;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      mem_ready = k[0];
      chk($sformatf("halt%0d.outputs", k), {bus_sel, alu_op, reg_in, misc_act}, 96'd0);
      @(negedge clk);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("halt_clr.strobes", {bus_sel, alu_op, reg_in, misc_act}, {32'd0, 13'd0, 16'd0, M_RUN | M_RD});
    chk("halt_clr.mem_addr", mem_addr, 96'd10);

    mem_ready = 1'b1;
    n = 0;
    while (!alu_op[12] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mul_e1.cycles", n, 96'd7);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("mul_clr.ir", ir, 96'd0);
    chk("mul_clr.strobes", {bus_sel, alu_op, reg_in, misc_act}, {32'd0, 13'd0, 16'd0, M_RUN | M_RD});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mul_clr%0d.loads", k), {hi_in, lo_in, reg_in}, 96'd0);
    end
    chk("mul_clr.hi", hi, 96'd1);
    chk("mul_clr.lo", lo, 96'd0);
    chk("mul_clr.pc", pc_m, 96'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
